// File: rtl/endstop_pkg.sv
// endstop_pkg: shared homing FSM states and trigger-event record layout
package endstop_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_CLOCK, SAMPLE} home_st_e;
  localparam int CHAN_W = 4;
  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [31:0]       tstamp;
    logic              pin;
  } evt_t;
  localparam int EVT_W = $bits(evt_t);
endpackage

// File: rtl/endstop_evt_fifo.sv
// endstop_evt_fifo: synchronous trigger-event FIFO with full/empty flags
module endstop_evt_fifo
  import endstop_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W = EVT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign wr = push && (!full || pop);
  assign dout = mem[rp[AW-1:0]];
  // pointers; a full FIFO still accepts a push when the head leaves in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(pop && !empty);
    end
  // storage needs no reset: only slots between the pointers are ever visible
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/endstop_homing.sv
// endstop_homing: per-channel endstop homing FSMs, stepper stop requests and trigger event queue
module endstop_homing
  import endstop_pkg::*;
#(
  parameter int NENDSTOP = 8,
  parameter int NSTEPDIR = 6,
  parameter int SAMPLE_BITS = 24,
  parameter int EVT_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 systime,
  input  logic [NENDSTOP-1:0]         endstop_in,
  input  logic                        cfg_wr,
  input  logic [$clog2(NENDSTOP)-1:0] cfg_chan,
  input  logic [NSTEPDIR-1:0]         cfg_mask,
  input  logic                        home_wr,
  input  logic [31:0]                 home_time,
  input  logic [SAMPLE_BITS-1:0]      home_samples,
  input  logic [SAMPLE_BITS-1:0]      home_rest,
  input  logic                        home_pin,
  input  logic                        shutdown,
  output logic [NENDSTOP-1:0]         homing,
  output logic [NENDSTOP-1:0]         endstop,
  output logic [NSTEPDIR-1:0]         step_reset,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NENDSTOP)-1:0] evt_chan,
  output logic [31:0]                 evt_time,
  output logic                        evt_pin,
  output logic                        evt_overflow
);
  localparam int CW = $clog2(NENDSTOP);
  logic [NENDSTOP-1:0] sync1, trig, pending, cap_pin;
  logic [NSTEPDIR-1:0] smap [NENDSTOP];
  logic [31:0] cap_time [NENDSTOP];
  logic [NSTEPDIR-1:0] sr_n;
  logic [CW-1:0] sel;
  logic any, push, pop, full, empty;
  evt_t din, head;
  // two-flop synchroniser for the raw pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {endstop, sync1} <= '0;
    else {endstop, sync1} <= {sync1, endstop_in};
  for (genvar i = 0; i < NENDSTOP; i++) begin : g_ch
    home_st_e st, st_n;
    logic [SAMPLE_BITS-1:0] cnt, cnt_n, rest, rest_n, smp, rld;
    logic [31:0] ht, ct;
    logic pin, cp, t, arm;
    assign arm = home_wr && !shutdown && cfg_chan == CW'(i);
    assign homing[i] = st != IDLE;
    assign trig[i] = t;
    assign cap_time[i] = ct;
    assign cap_pin[i] = cp;
    // state and sample counters
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st <= IDLE;
        cnt <= '0;
        rest <= '0;
      end else begin
        st <= st_n;
        cnt <= cnt_n;
        rest <= rest_n;
      end
    // armed parameters and trigger capture
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        smp <= '0;
        rld <= '0;
        ht <= '0;
        pin <= 1'b0;
        ct <= '0;
        cp <= 1'b0;
      end else begin
        if (arm) begin
          smp <= home_samples;
          rld <= home_rest;
          ht <= home_time;
          pin <= home_pin;
        end
        if (t) begin
          ct <= systime;
          cp <= endstop[i];
        end
      end
    // shutdown beats arming, arming beats sampling; start time compared wrap-safe
    always_comb begin
      st_n = st;
      cnt_n = cnt;
      rest_n = rest;
      t = 1'b0;
      if (shutdown) st_n = IDLE;
      else if (arm) st_n = home_samples == '0 ? IDLE : WAIT_CLOCK;
      else if (st == WAIT_CLOCK && $signed(systime - ht) >= 0) begin
        st_n = SAMPLE;
        cnt_n = smp;
        rest_n = '0;
      end else if (st == SAMPLE && rest != '0) rest_n = rest - SAMPLE_BITS'(1);
      else if (st == SAMPLE) begin
        rest_n = rld;
        if (endstop[i] != pin) cnt_n = smp;
        else if (cnt == SAMPLE_BITS'(1)) begin
          t = 1'b1;
          st_n = IDLE;
        end else cnt_n = cnt - SAMPLE_BITS'(1);
      end
    end
  end
  // union of the maps of every channel triggering this cycle
  always_comb begin
    sr_n = '0;
    for (int k = 0; k < NENDSTOP; k++) if (trig[k]) sr_n |= smap[k];
  end
  // stepper maps and one-cycle stop request; map reads above see the pre-write value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      step_reset <= '0;
      for (int k = 0; k < NENDSTOP; k++) smap[k] <= '0;
    end else begin
      step_reset <= shutdown ? '1 : sr_n;
      if (cfg_wr) smap[cfg_chan] <= cfg_mask;
    end
  // lowest pending channel wins the single push slot
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = NENDSTOP - 1; k >= 0; k--)
      if (pending[k]) begin
        sel = CW'(k);
        any = 1'b1;
      end
  end
  assign push = any && !shutdown;
  assign pop = evt_ready && !empty;
  assign din = '{chan: CHAN_W'(sel), tstamp: cap_time[sel], pin: cap_pin[sel]};
  // pending set on trigger, cleared on push (even when dropped); drops are sticky
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pending <= shutdown ? '0 : (pending & ~(push ? NENDSTOP'(1) << sel : '0)) | trig;
      if (push && full && !pop) evt_overflow <= 1'b1;
    end
  endstop_evt_fifo #(.DEPTH(EVT_DEPTH), .W(EVT_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(din),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign evt_valid = !empty;
  assign evt_chan = CW'(head.chan);
  assign evt_time = head.tstamp;
  assign evt_pin = head.pin;
endmodule

// File: tb/tb_endstop_homing.sv
// tb_endstop_homing: table-driven and directed checks of endstop homing
module tb_endstop_homing;
  localparam int N = 8, NS = 6, SB = 24, D = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] systime = '0;
  logic [N-1:0] endstop_in = '1;
  logic cfg_wr = 1'b0, home_wr = 1'b0, home_pin = 1'b0, shutdown = 1'b0, evt_ready = 1'b0;
  logic [2:0] cfg_chan = '0;
  logic [NS-1:0] cfg_mask = '0;
  logic [31:0] home_time = '0;
  logic [SB-1:0] home_samples = '0, home_rest = '0;
  logic [N-1:0] homing, endstop;
  logic [NS-1:0] step_reset;
  logic evt_valid, evt_pin, evt_overflow;
  logic [2:0] evt_chan;
  logic [31:0] evt_time;
  int npass = 0, ntot = 0;

  typedef struct packed {
    logic [2:0] chan;
    logic [31:0] t0, ht;
    logic [SB-1:0] n, r;
    logic pin;
    logic [NS-1:0] mask;
    logic [31:0] et;
  } vec_t;
  vec_t tv [9];

  endstop_homing #(.NENDSTOP(N), .NSTEPDIR(NS), .SAMPLE_BITS(SB), .EVT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .systime(systime), .endstop_in(endstop_in),
    .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_mask(cfg_mask), .home_wr(home_wr),
    .home_time(home_time), .home_samples(home_samples), .home_rest(home_rest),
    .home_pin(home_pin), .shutdown(shutdown), .homing(homing), .endstop(endstop),
    .step_reset(step_reset), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_chan(evt_chan), .evt_time(evt_time), .evt_pin(evt_pin), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    systime = systime + 1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic cfg(input int c, input logic [NS-1:0] m);
    cfg_wr = 1'b1;
    cfg_chan = 3'(c);
    cfg_mask = m;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic arm(input int c, input logic [31:0] ht, input logic [SB-1:0] n, input logic [SB-1:0] r, input logic p);
    home_wr = 1'b1;
    cfg_chan = 3'(c);
    home_time = ht;
    home_samples = n;
    home_rest = r;
    home_pin = p;
    step();
    home_wr = 1'b0;
  endtask

  task automatic pop1();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int nsr;
    logic [31:0] s0, tr;
    tv[0] = '{3'd2, 32'd1000, 32'd1100, 24'd3, 24'd0, 1'b1, 6'b000101, 32'd1103};
    tv[1] = '{3'd5, 32'd2000, 32'd2010, 24'd1, 24'd0, 1'b0, 6'b110000, 32'd2011};
    tv[2] = '{3'd0, 32'd3000, 32'd3005, 24'd2, 24'd4, 1'b1, 6'b000011, 32'd3011};
    tv[3] = '{3'd7, 32'd4000, 32'd3990, 24'd2, 24'd0, 1'b1, 6'b111111, 32'd4003};
    tv[4] = '{3'd3, 32'd5000, 32'd5000, 24'd4, 24'd1, 1'b0, 6'b001000, 32'd5008};
    tv[5] = '{3'd1, 32'd6000, 32'd6020, 24'd5, 24'd2, 1'b1, 6'b010010, 32'd6033};
    tv[6] = '{3'd4, 32'hFFFFFF00, 32'hFFFFFFF0, 24'd20, 24'd0, 1'b1, 6'b100001, 32'h4};
    tv[7] = '{3'd6, 32'hFFFFFFF0, 32'h10, 24'd1, 24'd0, 1'b0, 6'b000110, 32'h11};
    tv[8] = '{3'd2, 32'd5, 32'hFFFFFFFB, 24'd2, 24'd0, 1'b1, 6'b000101, 32'd8};
    step();
    step();
    chk("rst_homing", homing, 0);
    chk("rst_endstop", endstop, 0);
    chk("rst_step_reset", step_reset, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_overflow", evt_overflow, 0);
    rst_n = 1'b1;
    for (int v = 0; v < 9; v++) begin
      endstop_in = {N{tv[v].pin}};
      cfg(tv[v].chan, tv[v].mask);
      step();
      step();
      systime = tv[v].t0;
      arm(tv[v].chan, tv[v].ht, tv[v].n, tv[v].r, tv[v].pin);
      chk("vec_armed", homing[tv[v].chan], 1);
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
        step();
        found = step_reset != '0;
      end
      chk("vec_trig_found", found, 1);
      chk("vec_trig_time", systime - 1, tv[v].et);
      chk("vec_step_reset", step_reset, tv[v].mask);
      chk("vec_disarmed", homing[tv[v].chan], 0);
      step();
      chk("vec_sr_one_cycle", step_reset, 0);
      chk("vec_evt_valid", evt_valid, 1);
      chk("vec_evt_chan", evt_chan, tv[v].chan);
      chk("vec_evt_time", evt_time, tv[v].et);
      chk("vec_evt_pin", evt_pin, tv[v].pin);
      pop1();
      chk("vec_evt_popped", evt_valid, 0);
    end
    // glitch rejection with sampling every fifth cycle
    endstop_in = '0;
    cfg(2, 6'b000101);
    step();
    step();
    systime = 32'd10000;
    arm(2, 32'd10001, 24'd3, 24'd4, 1'b1);
    nsr = 0;
    tr = '0;
    for (int k = 0; k < 40; k++) begin
      endstop_in[2] = (systime >= 32'd10004 && systime <= 32'd10010) || systime >= 32'd10016;
      step();
      if (step_reset != '0) begin
        nsr++;
        tr = systime - 1;
      end
    end
    chk("glitch_sr_count", nsr, 1);
    chk("glitch_trig_time", tr, 32'd10032);
    chk("glitch_evt_time", evt_time, 32'd10032);
    pop1();
    chk("glitch_single_evt", evt_valid, 0);
    // two channels triggering in the same cycle
    endstop_in = '1;
    cfg(0, 6'b000001);
    cfg(3, 6'b001000);
    step();
    step();
    s0 = systime;
    arm(0, s0 + 10, 24'd1, 24'd0, 1'b1);
    arm(3, s0 + 10, 24'd1, 24'd0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      found = step_reset != '0;
    end
    chk("dual_trig_time", systime - 1, s0 + 11);
    chk("dual_step_reset", step_reset, 6'b001001);
    step();
    chk("dual_first_chan", evt_chan, 0);
    step();
    step();
    step();
    chk("dual_hold_valid", evt_valid, 1);
    chk("dual_hold_chan", evt_chan, 0);
    chk("dual_hold_time", evt_time, s0 + 11);
    pop1();
    chk("dual_second_chan", evt_chan, 3);
    chk("dual_second_time", evt_time, s0 + 11);
    pop1();
    chk("dual_drained", evt_valid, 0);
    // fill FIFO past depth
    s0 = systime;
    for (int c = 0; c < N; c++) arm(c, s0 + 20, 24'd1, 24'd0, 1'b1);
    repeat (25) step();
    chk("ovf_not_yet", evt_overflow, 0);
    arm(0, systime + 2, 24'd1, 24'd0, 1'b1);
    repeat (10) step();
    chk("ovf_set", evt_overflow, 1);
    for (int c = 0; c < N; c++) begin
      chk("ovf_kept_chan", evt_chan, c);
      chk("ovf_kept_time", evt_time, s0 + 21);
      pop1();
    end
    chk("ovf_drained", evt_valid, 0);
    chk("ovf_sticky", evt_overflow, 1);
    // shutdown while three channels armed
    s0 = systime;
    arm(1, s0 + 6, 24'd3, 24'd0, 1'b1);
    arm(2, s0 + 6, 24'd3, 24'd0, 1'b1);
    arm(3, s0 + 6, 24'd3, 24'd0, 1'b1);
    chk("sd_armed", homing, 8'b00001110);
    shutdown = 1'b1;
    arm(4, systime + 2, 24'd1, 24'd0, 1'b1);
    chk("sd_homing", homing, 0);
    chk("sd_step_reset", step_reset, 6'h3F);
    step();
    chk("sd_step_reset_hold", step_reset, 6'h3F);
    chk("sd_home_wr_ignored", homing, 0);
    shutdown = 1'b0;
    step();
    chk("sd_released", step_reset, 0);
    nsr = 0;
    repeat (20) begin
      step();
      if (step_reset != '0) nsr++;
    end
    chk("sd_no_trig", nsr, 0);
    chk("sd_no_evt", evt_valid, 0);
    // cancel through zero sample count
    s0 = systime;
    arm(5, s0 + 3, 24'd2, 24'd0, 1'b1);
    chk("cancel_armed", homing[5], 1);
    arm(5, s0 + 3, 24'd0, 24'd0, 1'b1);
    chk("cancel_idle", homing[5], 0);
    nsr = 0;
    repeat (15) begin
      step();
      if (step_reset != '0) nsr++;
    end
    chk("cancel_no_trig", nsr, 0);
    chk("cancel_no_evt", evt_valid, 0);
    // asynchronous reset mid-sample
    s0 = systime;
    arm(2, s0 + 1, 24'd10, 24'd0, 1'b1);
    repeat (5) step();
    chk("ar_sampling", homing[2], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_homing", homing, 0);
    chk("ar_endstop", endstop, 0);
    chk("ar_step_reset", step_reset, 0);
    chk("ar_evt_valid", evt_valid, 0);
    chk("ar_overflow", evt_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nsr = 0;
    repeat (30) begin
      step();
      if (step_reset != '0) nsr++;
    end
    chk("ar_no_trig", nsr, 0);
    chk("ar_not_rearmed", homing, 0);
    chk("ar_no_evt", evt_valid, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
